// File: rtl/prog_lut_pkg.sv
// Shared types and constants for the programmable truth-table unit.
package prog_lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } ld_state_e;

  // Reset table reproducing the legacy cell: out0 = (A&B)|~C, out1 = ~C
  localparam logic [15:0] DEFAULT_INIT = 16'h0F8F;

  function automatic int tbl_bits(input int n_in, input int n_out);
    return n_out * (32'sd1 << n_in);
  endfunction

endpackage

// File: rtl/prog_lut_unit_loader.sv
// Serial table loader: LOAD/COMMIT FSM, bit counter and shadow table.
module lut_cfg_loader
  import prog_lut_pkg::*;
#(
  parameter int TBL = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_start,
  input  logic           cfg_valid,
  input  logic           cfg_bit,
  output logic           cfg_ready,
  output logic           cfg_done,
  output logic           busy,
  output logic           commit,
  output logic [TBL-1:0] shadow
);

  localparam int CNT_W = $clog2(TBL + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TBL - 1);

  ld_state_e        state_r;
  ld_state_e        state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [TBL-1:0]   shadow_r;
  logic             done_r;
  logic             accept_s;
  logic             last_s;
  logic             ready_s;
  logic             busy_s;
  logic             commit_s;

  // A restart pulse takes priority over the bit offered in the same cycle
  assign accept_s = cfg_valid && (state_r == LOAD) && !cfg_start;
  assign last_s   = accept_s && (cnt_r == LAST_IDX);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cfg_start) state_s = LOAD;
        else           state_s = IDLE;
      end
      LOAD: begin
        if (last_s) state_s = COMMIT;
        else        state_s = LOAD;
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    ready_s  = 1'b0;
    busy_s   = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s  = 1'b0;
        busy_s   = 1'b0;
        commit_s = 1'b0;
      end
      LOAD: begin
        ready_s  = 1'b1;
        busy_s   = 1'b1;
        commit_s = 1'b0;
      end
      COMMIT: begin
        ready_s  = 1'b0;
        busy_s   = 1'b1;
        commit_s = 1'b1;
      end
      default: begin
        ready_s  = 1'b0;
        busy_s   = 1'b0;
        commit_s = 1'b0;
      end
    endcase
  end

  // bit counter, shadow table and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      shadow_r <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= (state_r == COMMIT);
      if (cfg_start && (state_r != COMMIT)) begin
        cnt_r <= '0;
      end else if (accept_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      for (int i = 0; i < TBL; i++) begin
        if (accept_s && (cnt_r == CNT_W'(i))) begin
          shadow_r[i] <= cfg_bit;
        end
      end
    end
  end

  assign cfg_ready = ready_s;
  assign busy      = busy_s;
  assign commit    = commit_s;
  assign cfg_done  = done_r;
  assign shadow    = shadow_r;

endmodule

// File: rtl/prog_lut_unit.sv
// Runtime-programmable registered truth-table unit with atomic table reload.
// Optional input stability filter enabled by defining LUT_INPUT_FILTER_EN.
module prog_lut_unit
  import prog_lut_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter logic [tbl_bits(N_IN, N_OUT)-1:0] INIT = DEFAULT_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_IN-1:0]  in_vec,
  output logic [N_OUT-1:0] out_vec,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             busy
);

  localparam int DEPTH = 2 ** N_IN;
  localparam int TBL   = tbl_bits(N_IN, N_OUT);

  logic [TBL-1:0]   active_r;
  logic [TBL-1:0]   shadow_s;
  logic             commit_s;
  logic [N_OUT-1:0] out_r;
  logic [N_OUT-1:0] lut_s;
  logic [DEPTH-1:0] row_s;
  logic             upd_ok_s;

  lut_cfg_loader #(
    .TBL(TBL)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_bit  (cfg_bit),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .busy     (busy),
    .commit   (commit_s),
    .shadow   (shadow_s)
  );

  // active table: replaced only as a whole at commit
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= INIT;
    end else if (commit_s) begin
      active_r <= shadow_s;
    end else begin
      active_r <= active_r;
    end
  end

  // per-output row lookup addressed by in_vec
  always_comb begin
    lut_s = '0;
    row_s = '0;
    for (int o = 0; o < N_OUT; o++) begin
      row_s    = active_r[o*DEPTH +: DEPTH];
      lut_s[o] = row_s[in_vec];
    end
  end

`ifdef LUT_INPUT_FILTER_EN
  logic [N_IN-1:0] in_q_r;

  // previous input sample for the stability check
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q_r <= '0;
    end else begin
      in_q_r <= in_vec;
    end
  end

  assign upd_ok_s = (in_vec == in_q_r);
`else
  assign upd_ok_s = 1'b1;
`endif

  // evaluation register; holds when disabled or input unsettled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= '0;
    end else if (en && upd_ok_s) begin
      out_r <= lut_s;
    end else begin
      out_r <= out_r;
    end
  end

  assign out_vec = out_r;

endmodule
